// File: rtl/ls_sequencer.sv
// Load/store sequencer between the execute stage and the data memory.
// Takes one request at a time and issues one memory access per cycle.
// Completion is reported to writeback with a single-cycle response pulse.
module ls_sequencer #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [AW-1:0] req_len,
    output logic [AW-1:0] mem_addr,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_lo,
    output logic [DW-1:0] resp_hi,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, WR, CP_RD, CP_WR, RESP
    } state_t;

    localparam logic [1:0] OP_LB  = 2'b00;
    localparam logic [1:0] OP_SB  = 2'b01;
    localparam logic [1:0] OP_LP  = 2'b10;
    localparam logic [1:0] OP_CPY = 2'b11;

    state_t        r_state;
    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;   // store data, or copy destination base
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_idx;
    logic [DW-1:0] r_lo;
    logic [DW-1:0] r_hi;
    logic [DW-1:0] r_hold;    // byte in flight between CP_RD and CP_WR

    logic [AW-1:0] w_idx_nx;
    assign w_idx_nx = r_idx + 1'b1;

    // Request sequencing: capture on accept, walk the access states, one-cycle RESP.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_len   <= req_len;
                        r_idx   <= '0;
                        r_lo    <= '0;
                        r_hi    <= '0;
                        case (req_op)
                            OP_LB, OP_LP: r_state <= RD0;
                            OP_SB:        r_state <= WR;
                            default:      r_state <= (req_len == '0) ? RESP : CP_RD;
                        endcase
                    end
                end
                RD0: begin
                    r_lo    <= mem_rdata;
                    r_state <= (r_op == OP_LP) ? RD1 : RESP;
                end
                RD1: begin
                    r_hi    <= mem_rdata;
                    r_state <= RESP;
                end
                WR:    r_state <= RESP;
                CP_RD: begin
                    r_hold  <= mem_rdata;
                    r_state <= CP_WR;
                end
                CP_WR: begin
                    r_idx   <= w_idx_nx;
                    r_state <= (w_idx_nx < r_len) ? CP_RD : RESP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory strobes and address/data decoded from state; silenced while reset is high.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            case (r_state)
                RD0: begin
                    mem_read = 1'b1;
                    mem_addr = r_addr;
                end
                RD1: begin
                    mem_read = 1'b1;
                    mem_addr = r_addr + 1'b1;
                end
                WR: begin
                    mem_write = 1'b1;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                end
                CP_RD: begin
                    mem_read = 1'b1;
                    mem_addr = r_addr + r_idx;
                end
                CP_WR: begin
                    mem_write = 1'b1;
                    mem_addr  = AW'(r_wdata) + r_idx;
                    mem_wdata = r_hold;
                end
                default: ;
            endcase
        end
    end

    // Response fields are only driven during the RESP pulse; copies report their length.
    always_comb begin
        resp_valid = (r_state == RESP) && !reset;
        resp_lo    = '0;
        resp_hi    = '0;
        if (resp_valid) begin
            resp_lo = (r_op == OP_CPY) ? DW'(r_len) : r_lo;
            resp_hi = (r_op == OP_LP)  ? r_hi : '0;
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer with a behavioural byte memory.
module tb_ls_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_addr, req_wdata, req_len;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_read, mem_write;
    logic       resp_valid;
    logic [7:0] resp_lo, resp_hi;
    logic       busy;

    logic [7:0] mem [256];
    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];

    ls_sequencer #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_lo(resp_lo), .resp_hi(resp_hi),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; the memory commits a write strobed just before the edge.
    task automatic tick();
        logic       w;
        logic [7:0] a, d;
        #8;
        w = mem_write; a = mem_addr; d = mem_wdata;
        @(posedge CLK);
        #1;
        if (w === 1'b1) mem[a] = d;
    endtask

    // Present a request for one accept edge; returns in cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] ln);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_len = ln;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        req_addr = 8'h00; req_wdata = 8'h00; req_len = 8'h00;
        #1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", mem_read, 0);
        chk("rst_wr", mem_write, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_resp", resp_valid, 0);

        // LB
        mem[8'h10] = 8'd254;
        issue(2'b00, 8'h10, 8'h00, 8'h00);
        chk("lb_rd", mem_read, 1);
        chk("lb_addr", mem_addr, 8'h10);
        chk("lb_ready1", req_ready, 0);
        tick();
        chk("lb_resp", resp_valid, 1);
        chk("lb_lo", resp_lo, 254);
        chk("lb_hi", resp_hi, 0);
        chk("lb_ready2", req_ready, 0);
        tick();
        chk("lb_resp_end", resp_valid, 0);
        chk("lb_lo_idle", resp_lo, 0);
        chk("lb_ready3", req_ready, 1);

        // SB
        issue(2'b01, 8'h20, 8'hA5, 8'h00);
        chk("sb_wr", mem_write, 1);
        chk("sb_rd", mem_read, 0);
        chk("sb_addr", mem_addr, 8'h20);
        chk("sb_wdata", mem_wdata, 8'hA5);
        tick();
        chk("sb_resp", resp_valid, 1);
        chk("sb_lo", resp_lo, 0);
        chk("sb_wr_once", mem_write, 0);
        chk("sb_mem", mem[8'h20], 8'hA5);
        tick();

        // LP
        mem[8'h21] = 8'h3C;
        issue(2'b10, 8'h20, 8'h00, 8'h00);
        chk("lp_addr0", mem_addr, 8'h20);
        tick();
        chk("lp_rd1", mem_read, 1);
        chk("lp_addr1", mem_addr, 8'h21);
        tick();
        chk("lp_resp", resp_valid, 1);
        chk("lp_lo", resp_lo, 8'hA5);
        chk("lp_hi", resp_hi, 8'h3C);
        tick();

        // LP across address wrap
        mem[8'hFF] = 8'h11; mem[8'h00] = 8'h22;
        issue(2'b10, 8'hFF, 8'h00, 8'h00);
        chk("lpw_addr0", mem_addr, 8'hFF);
        tick();
        chk("lpw_addr1", mem_addr, 8'h00);
        chk("lpw_rd1", mem_read, 1);
        tick();
        chk("lpw_lo", resp_lo, 8'h11);
        chk("lpw_hi", resp_hi, 8'h22);
        tick();

        // CPY 0x40 -> 0x80, len 3
        mem[8'h40] = 8'd1; mem[8'h41] = 8'd2; mem[8'h42] = 8'd3;
        issue(2'b11, 8'h40, 8'h80, 8'd3);
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                chk("cp_rd", mem_read, 1);
                chk("cp_rd_addr", mem_addr, 8'h40 + k / 2);
            end else begin
                chk("cp_wr", mem_write, 1);
                chk("cp_wr_addr", mem_addr, 8'h80 + k / 2);
                chk("cp_wdata", mem_wdata, k / 2 + 1);
            end
            tick();
        end
        chk("cp_resp", resp_valid, 1);
        chk("cp_lo", resp_lo, 3);
        chk("cp_strobe_off", {mem_read, mem_write}, 0);
        tick();
        chk("cp_m80", mem[8'h80], 1);
        chk("cp_m81", mem[8'h81], 2);
        chk("cp_m82", mem[8'h82], 3);

        // CPY len 0
        issue(2'b11, 8'h40, 8'h80, 8'd0);
        chk("cp0_resp", resp_valid, 1);
        chk("cp0_lo", resp_lo, 0);
        chk("cp0_strobes", {mem_read, mem_write}, 0);
        tick();

        // Overlapping copy: dst = src + 1
        mem[8'h50] = 8'd9;
        for (int i = 1; i <= 4; i++) mem[8'h50 + i] = 8'd0;
        issue(2'b11, 8'h50, 8'h51, 8'd4);
        for (int k = 0; k < 8; k++) tick();
        chk("ov_resp", resp_valid, 1);
        chk("ov_lo", resp_lo, 4);
        tick();
        for (int i = 1; i <= 4; i++) chk("ov_mem", mem[8'h50 + i], 9);

        // Reset during CP_WR of a len-4 copy
        mem[8'h60] = 8'd5; mem[8'h61] = 8'd6; mem[8'h62] = 8'd7; mem[8'h63] = 8'd8;
        for (int i = 0; i < 4; i++) mem[8'h90 + i] = 8'd0;
        issue(2'b11, 8'h60, 8'h90, 8'd4);
        tick(); tick(); tick();
        chk("rc_wr_pre", mem_write, 1);
        chk("rc_addr_pre", mem_addr, 8'h91);
        reset = 1'b1;
        #1;
        chk("rc_wr_rst", mem_write, 0);
        chk("rc_rd_rst", mem_read, 0);
        chk("rc_resp_rst", resp_valid, 0);
        tick();
        reset = 1'b0;
        chk("rc_ready", req_ready, 1);
        chk("rc_busy", busy, 0);
        chk("rc_resp", resp_valid, 0);
        chk("rc_m90", mem[8'h90], 5);
        chk("rc_m91", mem[8'h91], 0);
        tick();
        chk("rc_resp2", resp_valid, 0);
        issue(2'b00, 8'h10, 8'h00, 8'h00);
        tick();
        chk("rc_lb_resp", resp_valid, 1);
        chk("rc_lb_lo", resp_lo, 254);
        tick();

        // Request coincident with reset is dropped
        mem[8'h30] = 8'h00;
        reset = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_addr = 8'h30; req_wdata = 8'h77;
        tick();
        reset = 1'b0; req_valid = 1'b0;
        chk("rv_busy", busy, 0);
        tick();
        chk("rv_busy2", busy, 0);
        chk("rv_mem", mem[8'h30], 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ls_sequencer.md
Name: ls_sequencer

Overview:
- Load/store sequencer directly upstream of the processor's data memory.
- Accepts one memory request at a time from the core's execute stage via valid/ready. Four request types: byte load, byte store, paired load (two adjacent bytes), block copy.
- Drives the data memory's single address pointer and read/write strobes, one memory access per cycle.
- Returns results to writeback with a one-cycle response pulse.

Parameters:
- AW, 8, address width; all address arithmetic wraps modulo 2^AW.
- DW, 8, data width of memory and result bytes.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  2  request type: 00 LB, 01 SB, 10 LP (paired load), 11 CPY.
- req_addr  in  AW  byte address (LB/SB/LP); source base (CPY).
- req_wdata  in  DW  store data (SB); destination base (CPY).
- req_len  in  AW  byte count (CPY only; ignored otherwise).
- mem_addr  out  AW  memory address.
- mem_read  out  1  memory read strobe; read data is combinational, same cycle.
- mem_write  out  1  memory write strobe; write commits at posedge.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_lo  out  DW  LB/LP: byte at addr. CPY: bytes copied. SB: 0.
- resp_hi  out  DW  LP: byte at addr+1. Otherwise 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, RD0, RD1, WR, CP_RD, CP_WR, RESP.
- Acceptance:
  - A request is accepted on a posedge where req_valid && req_ready.
  - op, addr, wdata and len are captured into registers at that edge.
  - Inputs are ignored outside IDLE.
- Strobes:
  - mem_read and mem_write are decoded from state and are never both high.
  - Both are forced 0 combinationally while reset=1.
  - When neither strobe is active: mem_addr=0, mem_wdata=0.
- Timing below takes the accept edge as the end of cycle T.
- LB:
  - T+1: RD0, mem_read=1, mem_addr=addr; mem_rdata latched into lo register.
  - T+2: RESP, resp_valid=1, resp_lo=M[addr], resp_hi=0.
  - T+3: IDLE.
- LP:
  - T+1: RD0 at addr.
  - T+2: RD1 at (addr+1) mod 2^AW; this wraps 0xFF→0x00.
  - T+3: RESP, resp_lo=M[addr], resp_hi=M[addr+1].
- SB:
  - T+1: WR, mem_write=1, mem_addr=addr, mem_wdata=wdata.
  - T+2: RESP, resp_lo=resp_hi=0.
- CPY:
  - Maintains an index i, starting at 0.
  - CP_RD: mem_read=1 at src+i; byte latched into a hold register.
  - CP_WR: mem_write=1 at dst+i with the held byte; then i++.
  - Returns to CP_RD while i<len, otherwise goes to RESP.
  - Duration is 2*len cycles, then RESP with resp_lo=len.
  - len=0: T+1 is RESP directly with resp_lo=0 and no memory strobes.
  - src+i and dst+i wrap modulo 2^AW.
  - Overlapping regions copy strictly ascending, byte by byte. With dst=src+1, M[src] therefore propagates through the whole destination range.
- RESP:
  - Lasts exactly one cycle.
  - resp_lo/resp_hi are valid only while resp_valid=1; otherwise they hold 0.
  - IDLE follows unconditionally, and req_ready rises in the next cycle.
  - Back-to-back requests are therefore at least one idle cycle apart.
- Reset:
  - reset=1 at a posedge forces IDLE, i=0, all capture registers to 0, resp_valid=0.
  - Values after reset: req_ready=1, busy=0, mem strobes 0, mem_addr=0.
  - Mid-operation reset abandons the request with no response pulse. A partial CPY leaves already-written bytes in place.
  - No write reaches memory in any cycle where reset=1.
- Simultaneous req_valid and reset: reset wins and the request is not accepted.

Test Plan:
- Reset, then LB addr=0x10 with M[0x10]=254 → mem_read with mem_addr=0x10 at T+1; resp_valid at T+2 with resp_lo=254, resp_hi=0; req_ready low during T+1..T+2.
- SB addr=0x20 wdata=0xA5, then LP addr=0x20 with M[0x21]=0x3C → single write cycle at 0x20; LP resp_lo=0xA5, resp_hi=0x3C at T+3.
- LP addr=0xFF with M[0xFF]=0x11, M[0x00]=0x22 → RD1 mem_addr=0x00; resp_lo=0x11, resp_hi=0x22.
- CPY src=0x40 dst=0x80 len=3, with M[0x40..0x42]=1,2,3 → strobes alternate read/write for 6 cycles at addrs 40,80,41,81,42,82; M[0x80..0x82]=1,2,3; resp_lo=3.
- CPY len=0 → no strobes, resp_valid at T+1 with resp_lo=0. CPY src=0x50 dst=0x51 len=4 with M[0x50]=9 → M[0x51..0x54] all 9.
- Assert reset during CP_WR of a len=4 copy → no resp_valid pulse; strobes 0 in the reset cycle; IDLE/req_ready=1 next cycle; the next LB completes normally.
